id_ex_stage_reg: RTL and testbench

ID/EX pipeline register with integrated load-use hazard detection. It latches decoded operands, register specifiers and control from the ID stage every cycle. It drives the EX stage and the forwarding unit, which consumes the Rs, Rt, Rw and write-back outputs. When a load in EX targets a source register of the instruction in ID, it stalls PC and IF/ID for one cycle and inserts a bubble.

---
 rtl/id_ex_stage_reg.sv | 121 ++++++++++++
 tb/tb_id_ex_stage_reg.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection.
// Every cycle it captures the decoded instruction from ID. A load in EX whose
// destination is read by the instruction in ID holds PC and IF/ID for one
// cycle, and a NOP bubble is inserted into EX in its place. A taken
// branch/jump (flush) also inserts a bubble, but it never raises stall.
module id_ex_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [4:0]        id_Rs,
    input  logic [4:0]        id_Rt,
    input  logic [4:0]        id_Rw,
    input  logic              id_uses_rt,
    input  logic [DATA_W-1:0] id_busA,
    input  logic [DATA_W-1:0] id_busB,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_reg_wr,
    input  logic              id_mem_to_reg,
    input  logic              id_mem_wr,
    input  logic              id_alu_src,
    input  logic [3:0]        id_alu_ctr,
    output logic              stall,
    output logic              id_ex_valid,
    output logic [4:0]        id_ex_Rs,
    output logic [4:0]        id_ex_Rt,
    output logic [4:0]        id_ex_Rw,
    output logic [DATA_W-1:0] id_ex_busA,
    output logic [DATA_W-1:0] id_ex_busB,
    output logic [DATA_W-1:0] id_ex_imm,
    output logic              id_ex_wb,
    output logic              id_ex_mem_to_reg,
    output logic              id_ex_mem_wr,
    output logic              id_ex_alu_src,
    output logic [3:0]        id_ex_alu_ctr,
    output logic [CNT_W-1:0]  stall_count
);

    logic load_in_ex_s;
    logic rs_match_s;
    logic rt_match_s;
    logic hz_s;
    logic bubble_s;
    logic cnt_inc_s;

    // Detect a load in EX that feeds a source of the instruction in ID.
    always_comb begin
        // $0 is never written, so a load targeting it cannot create a dependency.
        load_in_ex_s = id_ex_valid & id_ex_mem_to_reg & (id_ex_Rw != 5'd0);
        rs_match_s   = (id_ex_Rw == id_Rs);
        // An I-type Rt field names a destination, not a source, so it is ignored.
        rt_match_s   = id_uses_rt & (id_ex_Rw == id_Rt);
        hz_s         = load_in_ex_s & id_valid & (rs_match_s | rt_match_s);
        // flush has priority over hz: the instruction in ID is discarded anyway.
        bubble_s     = flush | hz_s;
        cnt_inc_s    = hz_s & ~flush & (stall_count != {CNT_W{1'b1}});
    end

    // Once reset clears id_ex_valid, stall drops without waiting for a clock edge.
    assign stall = hz_s & ~flush;

    // Pipeline register: capture the ID instruction, or load an all-zero NOP bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_ex_valid      <= 1'b0;
            id_ex_Rs         <= 5'd0;
            id_ex_Rt         <= 5'd0;
            id_ex_Rw         <= 5'd0;
            id_ex_busA       <= {DATA_W{1'b0}};
            id_ex_busB       <= {DATA_W{1'b0}};
            id_ex_imm        <= {DATA_W{1'b0}};
            id_ex_wb         <= 1'b0;
            id_ex_mem_to_reg <= 1'b0;
            id_ex_mem_wr     <= 1'b0;
            id_ex_alu_src    <= 1'b0;
            id_ex_alu_ctr    <= 4'd0;
        end else if (bubble_s) begin
            // Rw is cleared so that the forwarding unit can never match a bubble.
            id_ex_valid      <= 1'b0;
            id_ex_Rs         <= 5'd0;
            id_ex_Rt         <= 5'd0;
            id_ex_Rw         <= 5'd0;
            id_ex_busA       <= {DATA_W{1'b0}};
            id_ex_busB       <= {DATA_W{1'b0}};
            id_ex_imm        <= {DATA_W{1'b0}};
            id_ex_wb         <= 1'b0;
            id_ex_mem_to_reg <= 1'b0;
            id_ex_mem_wr     <= 1'b0;
            id_ex_alu_src    <= 1'b0;
            id_ex_alu_ctr    <= 4'd0;
        end else begin
            id_ex_valid      <= id_valid;
            id_ex_Rs         <= id_Rs;
            id_ex_Rt         <= id_Rt;
            id_ex_Rw         <= id_Rw;
            id_ex_busA       <= id_busA;
            id_ex_busB       <= id_busB;
            id_ex_imm        <= id_imm;
            id_ex_wb         <= id_reg_wr & id_valid;
            id_ex_mem_to_reg <= id_mem_to_reg;
            id_ex_mem_wr     <= id_mem_wr;
            id_ex_alu_src    <= id_alu_src;
            id_ex_alu_ctr    <= id_alu_ctr;
        end
    end

    // Saturating count of load-use bubbles. Flush bubbles are not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= {CNT_W{1'b0}};
        end else if (cnt_inc_s) begin
            stall_count <= stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_count <= stall_count;
        end
    end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed, table-driven bench for id_ex_stage_reg.
// Each table row is one ID-stage instruction. It carries the hand-computed
// combinational stall seen before the edge, whether a bubble is expected, and
// the expected stall_count after the edge. A second instance with a 2-bit
// counter shares the stimulus, so counter saturation is reached in a few
// cycles.
module tb_id_ex_stage_reg;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        id_valid;
    logic [4:0]  id_Rs, id_Rt, id_Rw;
    logic        id_uses_rt;
    logic [31:0] id_busA, id_busB, id_imm;
    logic        id_reg_wr, id_mem_to_reg, id_mem_wr, id_alu_src;
    logic [3:0]  id_alu_ctr;

    logic        stall;
    logic        id_ex_valid;
    logic [4:0]  id_ex_Rs, id_ex_Rt, id_ex_Rw;
    logic [31:0] id_ex_busA, id_ex_busB, id_ex_imm;
    logic        id_ex_wb, id_ex_mem_to_reg, id_ex_mem_wr, id_ex_alu_src;
    logic [3:0]  id_ex_alu_ctr;
    logic [15:0] stall_count;

    logic        s_stall, s_valid, s_wb, s_m2r, s_mw, s_as;
    logic [4:0]  s_rs, s_rt, s_rw;
    logic [31:0] s_busA, s_busB, s_imm;
    logic [3:0]  s_ctr;
    logic [1:0]  s_count;

    int n_cmp = 0;
    int n_err = 0;

    id_ex_stage_reg #(.DATA_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .id_valid(id_valid),
        .id_Rs(id_Rs), .id_Rt(id_Rt), .id_Rw(id_Rw), .id_uses_rt(id_uses_rt),
        .id_busA(id_busA), .id_busB(id_busB), .id_imm(id_imm),
        .id_reg_wr(id_reg_wr), .id_mem_to_reg(id_mem_to_reg), .id_mem_wr(id_mem_wr),
        .id_alu_src(id_alu_src), .id_alu_ctr(id_alu_ctr),
        .stall(stall), .id_ex_valid(id_ex_valid),
        .id_ex_Rs(id_ex_Rs), .id_ex_Rt(id_ex_Rt), .id_ex_Rw(id_ex_Rw),
        .id_ex_busA(id_ex_busA), .id_ex_busB(id_ex_busB), .id_ex_imm(id_ex_imm),
        .id_ex_wb(id_ex_wb), .id_ex_mem_to_reg(id_ex_mem_to_reg),
        .id_ex_mem_wr(id_ex_mem_wr), .id_ex_alu_src(id_ex_alu_src),
        .id_ex_alu_ctr(id_ex_alu_ctr), .stall_count(stall_count)
    );

    id_ex_stage_reg #(.DATA_W(32), .CNT_W(2)) sat (
        .clk(clk), .rst_n(rst_n), .flush(flush), .id_valid(id_valid),
        .id_Rs(id_Rs), .id_Rt(id_Rt), .id_Rw(id_Rw), .id_uses_rt(id_uses_rt),
        .id_busA(id_busA), .id_busB(id_busB), .id_imm(id_imm),
        .id_reg_wr(id_reg_wr), .id_mem_to_reg(id_mem_to_reg), .id_mem_wr(id_mem_wr),
        .id_alu_src(id_alu_src), .id_alu_ctr(id_alu_ctr),
        .stall(s_stall), .id_ex_valid(s_valid),
        .id_ex_Rs(s_rs), .id_ex_Rt(s_rt), .id_ex_Rw(s_rw),
        .id_ex_busA(s_busA), .id_ex_busB(s_busB), .id_ex_imm(s_imm),
        .id_ex_wb(s_wb), .id_ex_mem_to_reg(s_m2r),
        .id_ex_mem_wr(s_mw), .id_ex_alu_src(s_as),
        .id_ex_alu_ctr(s_ctr), .stall_count(s_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        flush;
        logic        valid;
        logic [4:0]  rs, rt, rw;
        logic        uses_rt;
        logic [31:0] busA, busB, imm;
        logic        wr, m2r, mw, as;
        logic [3:0]  ctr;
        logic        exp_stall;
        logic        exp_bubble;
        logic [15:0] exp_cnt;
    } vec_t;

    localparam int NV = 19;
    vec_t tbl [NV];

    function automatic vec_t mk(int fl, int vl, int rs, int rt, int rw, int ur,
                                int a, int b, int im, int wr, int m2r, int mw,
                                int as, int ctr, int es, int eb, int ec);
        vec_t v;
        v.flush = 1'(fl);   v.valid = 1'(vl);
        v.rs = 5'(rs);      v.rt = 5'(rt);     v.rw = 5'(rw);
        v.uses_rt = 1'(ur);
        v.busA = 32'(a);    v.busB = 32'(b);   v.imm = 32'(im);
        v.wr = 1'(wr);      v.m2r = 1'(m2r);   v.mw = 1'(mw);
        v.as = 1'(as);      v.ctr = 4'(ctr);
        v.exp_stall = 1'(es); v.exp_bubble = 1'(eb); v.exp_cnt = 16'(ec);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        flush = v.flush; id_valid = v.valid;
        id_Rs = v.rs; id_Rt = v.rt; id_Rw = v.rw; id_uses_rt = v.uses_rt;
        id_busA = v.busA; id_busB = v.busB; id_imm = v.imm;
        id_reg_wr = v.wr; id_mem_to_reg = v.m2r; id_mem_wr = v.mw;
        id_alu_src = v.as; id_alu_ctr = v.ctr;
    endtask

    // Expected EX contents: all zero for a bubble, otherwise the captured instruction.
    task automatic chk_ex(input string tag, input vec_t v);
        logic b;
        b = v.exp_bubble;
        chk({tag, ".valid"}, 64'(id_ex_valid), b ? 64'd0 : 64'(v.valid));
        chk({tag, ".Rs"},    64'(id_ex_Rs),    b ? 64'd0 : 64'(v.rs));
        chk({tag, ".Rt"},    64'(id_ex_Rt),    b ? 64'd0 : 64'(v.rt));
        chk({tag, ".Rw"},    64'(id_ex_Rw),    b ? 64'd0 : 64'(v.rw));
        chk({tag, ".busA"},  64'(id_ex_busA),  b ? 64'd0 : 64'(v.busA));
        chk({tag, ".busB"},  64'(id_ex_busB),  b ? 64'd0 : 64'(v.busB));
        chk({tag, ".imm"},   64'(id_ex_imm),   b ? 64'd0 : 64'(v.imm));
        chk({tag, ".wb"},    64'(id_ex_wb),    b ? 64'd0 : 64'(v.wr & v.valid));
        chk({tag, ".m2r"},   64'(id_ex_mem_to_reg), b ? 64'd0 : 64'(v.m2r));
        chk({tag, ".mw"},    64'(id_ex_mem_wr),     b ? 64'd0 : 64'(v.mw));
        chk({tag, ".as"},    64'(id_ex_alu_src),    b ? 64'd0 : 64'(v.as));
        chk({tag, ".ctr"},   64'(id_ex_alu_ctr),    b ? 64'd0 : 64'(v.ctr));
        chk({tag, ".cnt"},   64'(stall_count), 64'(v.exp_cnt));
        chk({tag, ".satcnt"}, 64'(s_count), (v.exp_cnt > 16'd3) ? 64'd3 : 64'(v.exp_cnt));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".stall"}, 64'(stall), 64'd0);
        chk({tag, ".valid"}, 64'(id_ex_valid), 64'd0);
        chk({tag, ".Rs"}, 64'(id_ex_Rs), 64'd0);
        chk({tag, ".Rt"}, 64'(id_ex_Rt), 64'd0);
        chk({tag, ".Rw"}, 64'(id_ex_Rw), 64'd0);
        chk({tag, ".busA"}, 64'(id_ex_busA), 64'd0);
        chk({tag, ".busB"}, 64'(id_ex_busB), 64'd0);
        chk({tag, ".imm"}, 64'(id_ex_imm), 64'd0);
        chk({tag, ".wb"}, 64'(id_ex_wb), 64'd0);
        chk({tag, ".m2r"}, 64'(id_ex_mem_to_reg), 64'd0);
        chk({tag, ".mw"}, 64'(id_ex_mem_wr), 64'd0);
        chk({tag, ".as"}, 64'(id_ex_alu_src), 64'd0);
        chk({tag, ".ctr"}, 64'(id_ex_alu_ctr), 64'd0);
        chk({tag, ".cnt"}, 64'(stall_count), 64'd0);
        chk({tag, ".satcnt"}, 64'(s_count), 64'd0);
    endtask

    initial begin
        vec_t v;
        //           fl vl rs  rt  rw ur  busA busB imm wr m2r mw as ctr  stall bub cnt
        tbl[0]  = mk(0, 1,  1,  2,  3, 1,    5,   7,  0, 1, 0, 0, 0, 2,   0, 0, 0); // ADD passthrough
        tbl[1]  = mk(0, 1,  1,  8,  8, 0,  100,   0,  4, 1, 1, 0, 1, 2,   0, 0, 0); // LW $8
        tbl[2]  = mk(0, 1,  8,  2,  9, 1,   11,  22,  0, 1, 0, 0, 0, 2,   1, 1, 1); // ADD uses $8 -> stall
        tbl[3]  = mk(0, 1,  8,  2,  9, 1,   11,  22,  0, 1, 0, 0, 0, 2,   0, 0, 1); // ADD captured
        tbl[4]  = mk(0, 1,  2,  4,  4, 0,    0,   0,  8, 1, 1, 0, 1, 2,   0, 0, 1); // LW $4
        tbl[5]  = mk(0, 1,  5,  4,  6, 0,    3,   0,  3, 1, 0, 0, 1, 2,   0, 0, 1); // ADDI, Rt=4 not a source
        tbl[6]  = mk(0, 1,  0,  4,  4, 0,    0,   0, 12, 1, 1, 0, 1, 2,   0, 0, 1); // LW $4
        tbl[7]  = mk(0, 1,  5,  4,  0, 1,    9,  13, 16, 0, 0, 1, 1, 2,   1, 1, 2); // SW reads $4 -> stall
        tbl[8]  = mk(0, 1,  5,  4,  0, 1,    9,  13, 16, 0, 0, 1, 1, 2,   0, 0, 2); // SW captured
        tbl[9]  = mk(0, 1,  1,  0,  0, 0,    0,   0, 20, 1, 1, 0, 1, 2,   0, 0, 2); // LW $0
        tbl[10] = mk(0, 1,  0,  0,  5, 1,   33,  44,  0, 1, 0, 0, 0, 6,   0, 0, 2); // uses $0 -> no stall
        tbl[11] = mk(0, 1,  3, 10, 10, 0,    0,   0, 24, 1, 1, 0, 1, 2,   0, 0, 2); // LW $10
        tbl[12] = mk(1, 1, 10,  1,  7, 1,   55,  66,  0, 1, 0, 0, 0, 2,   0, 1, 2); // hazard + flush
        tbl[13] = mk(0, 1,  1, 11, 11, 0,    0,   0, 28, 1, 1, 0, 1, 2,   0, 0, 2); // LW $11
        tbl[14] = mk(0, 1, 11, 12, 12, 0,    0,   0, 32, 1, 1, 0, 1, 2,   1, 1, 3); // LW chained -> stall
        tbl[15] = mk(0, 1, 11, 12, 12, 0,    0,   0, 32, 1, 1, 0, 1, 2,   0, 0, 3); // LW captured
        tbl[16] = mk(0, 1, 12, 12, 13, 1,   77,  88,  0, 1, 0, 0, 0, 2,   1, 1, 4); // ADD uses $12 -> stall
        tbl[17] = mk(0, 1, 12, 12, 13, 1,   77,  88,  0, 1, 0, 0, 0, 2,   0, 0, 4); // ADD captured
        tbl[18] = mk(0, 0,  1,  2,  2, 1,   91,  92, 93, 1, 0, 0, 1, 9,   0, 0, 4); // invalid ID: wb=0

        rst_n = 1'b0;
        v = mk(0, 1, 1, 2, 3, 1, 5, 7, 0, 1, 0, 0, 0, 2, 0, 0, 0);
        apply(v);
        @(negedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            apply(tbl[i]);
            #2;
            chk($sformatf("row%0d.stall", i), 64'(stall), 64'(tbl[i].exp_stall));
            @(posedge clk);
            #1;
            chk_ex($sformatf("row%0d", i), tbl[i]);
            @(negedge clk);
        end

        // Reset asserted mid-stall: a LW $8 goes into EX, then a dependent ADD sits in ID.
        v = mk(0, 1, 0, 0, 8, 0, 1, 2, 3, 1, 1, 0, 1, 2, 0, 0, 4);
        apply(v);
        @(posedge clk);
        #1;
        chk("midrst.lw_m2r", 64'(id_ex_mem_to_reg), 64'd1);
        @(negedge clk);
        v = mk(0, 1, 8, 3, 9, 1, 4, 5, 0, 1, 0, 0, 0, 2, 0, 0, 0);
        apply(v);
        #2;
        chk("midrst.stall_before", 64'(stall), 64'd1);
        chk("midrst.cnt_before", 64'(stall_count), 64'd4);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        // After reset, the same ADD is captured normally, with no stall.
        #2;
        chk("postrst.stall", 64'(stall), 64'd0);
        @(posedge clk);
        #1;
        chk_ex("postrst", v);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
